// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx byte-stream arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    // Bits needed to index/count v values; never 0 so it can always size a vector.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: locked owner only, else first valid from ptr upward.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            lock,
    input  logic [PW-1:0]   owner,
    output logic            valid,
    output logic [PW-1:0]   index
);

    int unsigned j;

    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = 0;
        if (lock) begin
            valid = req[owner];
            index = owner;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                j = 32'(ptr) + k;
                if (j >= NREQ) j = j - NREQ;
                if (!valid && req[PW'(j)]) begin
                    valid = 1'b1;
                    index = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ byte-stream requesters with round-robin
// fairness and packet locking; sequences each byte on tx_en / tx_busy.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned START_TO = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [NREQ-1:0]   grant,
    output logic              locked,
    output logic              timeout_err,
    input  logic              clr_err
);

    localparam int unsigned PW = clog2(NREQ);
    localparam int unsigned CW = clog2(START_TO + 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [CW-1:0] cnt;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic          accept;
    logic [7:0]    lane [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign lane[g] = req_data[8*g +: 8];
    end

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .lock  (locked),
        .owner (owner),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign accept = (state == IDLE) && !tx_busy && pick_valid;

    // Ready is the accept strobe itself, so at most one bit can be high.
    always_comb begin
        req_ready = '0;
        if (accept) req_ready[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_en       <= 1'b0;
            tx_data     <= '0;
            grant       <= '0;
            locked      <= 1'b0;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            tx_en <= 1'b0;
            if (clr_err) timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data <= lane[pick_idx];
                        grant   <= NREQ'(1'b1) << pick_idx;
                        owner   <= pick_idx;
                        tx_en   <= 1'b1;
                        state   <= SEND;
                        if (req_last[pick_idx]) begin
                            locked <= 1'b0;
                            ptr    <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                        end else begin
                            locked <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    cnt   <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(START_TO - 1)) begin
                        // Byte is considered lost; lock is kept so the packet owner retries.
                        if (!clr_err) timeout_err <= 1'b1;
                        state <= IDLE;
                        if (!locked) grant <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                        if (!locked) grant <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=2, START_TO=4).
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ     = 2;
    localparam int unsigned START_TO = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [NREQ-1:0]   grant;
    logic              locked;
    logic              timeout_err;
    logic              clr_err;

    logic busy_ext;
    bit   model_en;
    int   busy_len;
    int   busy_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t           q0[$];
    beat_t           q1[$];
    int              start1;
    logic [7:0]      exp_d[$];
    logic [NREQ-1:0] exp_g[$];
    logic            exp_l[$];

    uart_tx_arbiter #(.NREQ(NREQ), .START_TO(START_TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant       (grant),
        .locked      (locked),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy for busy_len cycles starting the cycle after tx_en.
    always @(posedge clk or posedge reset) begin
        if (reset)                    busy_cnt <= 0;
        else if (model_en && tx_en)   busy_cnt <= busy_len;
        else if (busy_cnt != 0)       busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = busy_ext | (busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [NREQ-1:0] g, input logic l);
        exp_d.push_back(d);
        exp_g.push_back(g);
        exp_l.push_back(l);
    endtask

    // Requester models feed q0/q1; every tx_en is checked against the expected list.
    task automatic run_traffic(input string tag, input int max_cyc);
        int got;
        int n_exp;
        got   = 0;
        n_exp = exp_d.size();
        for (int c = 0; c < max_cyc && got < n_exp; c++) begin
            cyc();
            req_valid[0]   = (q0.size() != 0);
            req_data[7:0]  = (q0.size() != 0) ? q0[0].d : 8'h00;
            req_last[0]    = (q0.size() != 0) ? q0[0].l : 1'b0;
            req_valid[1]   = (c >= start1) && (q1.size() != 0);
            req_data[15:8] = (q1.size() != 0) ? q1[0].d : 8'h00;
            req_last[1]    = (q1.size() != 0) ? q1[0].l : 1'b0;
            #1;
            chk({tag, " one_ready"}, 32'($countones(req_ready) <= 1), 32'd1);
            if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
            if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
            if (tx_en) begin
                chk({tag, " data"},   32'(tx_data), 32'(exp_d[got]));
                chk({tag, " grant"},  32'(grant),   32'(exp_g[got]));
                chk({tag, " locked"}, 32'(locked),  32'(exp_l[got]));
                got++;
            end
        end
        chk({tag, " byte_count"}, 32'(got), 32'(n_exp));
        exp_d.delete();
        exp_g.delete();
        exp_l.delete();
        q0.delete();
        q1.delete();
        req_valid = '0;
    endtask

    task automatic wait_idle(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            cyc();
            #1;
            if (grant == '0 && !tx_busy && !locked) seen = 1'b1;
        end
        chk({tag, " idle_reached"}, 32'(seen), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        clr_err   = 1'b0;
        busy_ext  = 1'b0;
        model_en  = 1'b1;
        busy_len  = 1;
        start1    = 0;

        // Reset values
        cyc(); cyc(); #1;
        chk("rst tx_en",       32'(tx_en),       32'd0);
        chk("rst tx_data",     32'(tx_data),     32'd0);
        chk("rst grant",       32'(grant),       32'd0);
        chk("rst locked",      32'(locked),      32'd0);
        chk("rst timeout_err", 32'(timeout_err), 32'd0);
        chk("rst req_ready",   32'(req_ready),   32'd0);
        chk("rst ptr",         32'(dut.ptr),     32'd0);
        cyc();
        reset = 1'b0;

        // Single byte, busy for 10 cycles
        busy_len = 10;
        cyc();
        req_valid = 2'b01; req_data = 16'h0041; req_last = 2'b01;
        #1 chk("single ready", 32'(req_ready), 32'b01);
        cyc();
        req_valid = 2'b00;
        #1;
        chk("single tx_en",  32'(tx_en),   32'd1);
        chk("single data",   32'(tx_data), 32'h41);
        chk("single grant",  32'(grant),   32'b01);
        chk("single ptr",    32'(dut.ptr), 32'd1);
        chk("single ready0", 32'(req_ready), 32'd0);
        cyc(); #1;
        chk("single tx_en_off", 32'(tx_en),   32'd0);
        chk("single busy",      32'(tx_busy), 32'd1);
        repeat (10) cyc();
        #1;
        chk("single busy_fell",  32'(tx_busy), 32'd0);
        chk("single grant_hold", 32'(grant),   32'b01);
        cyc(); #1;
        chk("single grant_clr",  32'(grant),   32'd0);

        // Fairness: pointer starts at 1 so requester 1 goes first
        busy_len = 1;
        for (int k = 0; k < 3; k++) begin
            q0.push_back('{d: 8'(8'hA0 + k), l: 1'b1});
            q1.push_back('{d: 8'(8'hB0 + k), l: 1'b1});
        end
        start1 = 0;
        push_exp(8'hB0, 2'b10, 1'b0); push_exp(8'hA0, 2'b01, 1'b0);
        push_exp(8'hB1, 2'b10, 1'b0); push_exp(8'hA1, 2'b01, 1'b0);
        push_exp(8'hB2, 2'b10, 1'b0); push_exp(8'hA2, 2'b01, 1'b0);
        run_traffic("fair", 60);
        wait_idle("fair");
        chk("fair ptr", 32'(dut.ptr), 32'd1);

        // Packet lock: requester 1 waits for requester 0's 3-byte packet
        q0.push_back('{d: 8'hC0, l: 1'b0});
        q0.push_back('{d: 8'hC1, l: 1'b0});
        q0.push_back('{d: 8'hC2, l: 1'b1});
        q1.push_back('{d: 8'hD0, l: 1'b1});
        start1 = 1;
        push_exp(8'hC0, 2'b01, 1'b1); push_exp(8'hC1, 2'b01, 1'b1);
        push_exp(8'hC2, 2'b01, 1'b0); push_exp(8'hD0, 2'b10, 1'b0);
        run_traffic("lock", 60);
        wait_idle("lock");
        chk("lock ptr", 32'(dut.ptr), 32'd0);

        // Timeout: uart_tx never reports busy
        model_en = 1'b0;
        cyc();
        req_valid = 2'b01; req_data = 16'h00E0; req_last = 2'b01;
        #1 chk("to ready", 32'(req_ready), 32'b01);
        cyc();
        req_valid = 2'b00;
        #1 chk("to tx_en", 32'(tx_en), 32'd1);
        repeat (4) cyc();
        #1 chk("to not_yet", 32'(timeout_err), 32'd0);
        cyc(); #1;
        chk("to set",   32'(timeout_err), 32'd1);
        chk("to grant", 32'(grant),       32'd0);
        chk("to ptr",   32'(dut.ptr),     32'd1);
        cyc();
        clr_err = 1'b1;
        #1 chk("to sticky", 32'(timeout_err), 32'd1);
        cyc();
        clr_err = 1'b0;
        #1 chk("to cleared", 32'(timeout_err), 32'd0);

        // clr_err in the same cycle as a new timeout wins
        cyc();
        req_valid = 2'b10; req_data = 16'hF000; req_last = 2'b10;
        #1 chk("to2 ready", 32'(req_ready), 32'b10);
        cyc();
        req_valid = 2'b00;
        #1 chk("to2 data", 32'(tx_data), 32'hF0);
        repeat (4) cyc();
        clr_err = 1'b1;
        #1 chk("to2 before", 32'(timeout_err), 32'd0);
        cyc();
        clr_err = 1'b0;
        #1;
        chk("to2 clr_wins", 32'(timeout_err), 32'd0);
        chk("to2 ptr",      32'(dut.ptr),     32'd0);
        cyc(); #1;
        chk("to2 stays0",   32'(timeout_err), 32'd0);

        // External busy blocks acceptance until it falls
        model_en = 1'b1;
        busy_len = 1;
        cyc();
        busy_ext = 1'b1;
        req_valid = 2'b01; req_data = 16'h0055; req_last = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1 chk("ext blocked", 32'(req_ready), 32'd0);
            cyc();
        end
        busy_ext = 1'b0;
        #1 chk("ext accept", 32'(req_ready), 32'b01);
        cyc();
        req_valid = 2'b00;
        #1;
        chk("ext tx_en", 32'(tx_en),   32'd1);
        chk("ext data",  32'(tx_data), 32'h55);
        wait_idle("ext");

        // Async reset while waiting for a locked packet byte to finish
        busy_len = 10;
        cyc();
        req_valid = 2'b01; req_data = 16'h0077; req_last = 2'b00;
        #1 chk("ar ready", 32'(req_ready), 32'b01);
        cyc();
        req_data = 16'h0088; req_last = 2'b01;
        #1 chk("ar tx_en", 32'(tx_en), 32'd1);
        repeat (3) cyc();
        #1;
        chk("ar grant_pre",  32'(grant),   32'b01);
        chk("ar locked_pre", 32'(locked),  32'd1);
        chk("ar ptr_pre",    32'(dut.ptr), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("ar tx_en",  32'(tx_en),       32'd0);
        chk("ar grant",  32'(grant),       32'd0);
        chk("ar locked", 32'(locked),      32'd0);
        chk("ar terr",   32'(timeout_err), 32'd0);
        chk("ar ptr",    32'(dut.ptr),     32'd0);
        cyc();
        reset = 1'b0;
        #1 chk("ar first_ready", 32'(req_ready), 32'b01);
        cyc();
        req_valid = 2'b00;
        #1;
        chk("ar resend_tx_en", 32'(tx_en),   32'd1);
        chk("ar resend_data",  32'(tx_data), 32'h88);
        chk("ar resend_grant", 32'(grant),   32'b01);
        wait_idle("ar");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
